comparison_result_buffer: RTL and testbench

Registered FIFO stage directly downstream of the combinational comparison unit. Captures each `(o_eqA, o_status)` result pair under a valid/ready handshake and buffers up to `DEPTH` results. Presents them in order to the consumer (register file / status logic) and optionally keeps a sticky OR of all status flags seen since the last clear.

---
 rtl/comparison_result_buffer.sv | 135 +++++++++++++
 tb/tb_comparison_result_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/comparison_result_buffer.sv
// comparison_result_buffer
// Registered FIFO stage behind the combinational comparison unit. It buffers
// up to DEPTH {eqA, status} result pairs under a valid/ready handshake and
// presents them in order to the consumer.
// Optional feature macro: COMPARISON_BUF_STICKY_EN. When it is defined, a
// sticky OR of every accepted status nibble is kept. When it is undefined,
// o_sticky is tied to zero and i_clear_sticky is ignored.

module comparison_result_buffer #(
  parameter int K     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [K-1:0]               i_eqA,
  input  logic [3:0]                 i_status,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [K-1:0]               o_result,
  output logic [3:0]                 o_res_status,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [3:0]                 o_sticky,
  input  logic                       i_clear_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = K + 4;

  // Storage is deliberately left without a reset. Only the pointers and the count are cleared.
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Status is decoded from the registered count only, so there is no ready-through path.
  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign o_ready = ~full_s;
  assign o_valid = ~empty_s;
  assign o_count = count_q;

  assign push_s = i_valid & ~full_s;
  assign pop_s  = ~empty_s & i_ready;

  // The head entry is read straight from storage. It is only meaningful while o_valid is high.
  assign o_result     = mem_q[rd_ptr_q][EW-1:4];
  assign o_res_status = mem_q[rd_ptr_q][3:0];

  // Next-state pointer and occupancy logic. DEPTH is a power of two, so the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers are cleared asynchronously. Any in-flight entries are discarded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the accepted result pair into the slot at the write pointer.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {i_eqA, i_status};
    end
  end

`ifdef COMPARISON_BUF_STICKY_EN
  logic [3:0] sticky_q, sticky_d;

  // A clear wipes the old value before the newly pushed status is OR-ed in.
  always_comb begin
    sticky_d = sticky_q;
    if (i_clear_sticky) begin
      sticky_d = 4'b0000;
    end else begin
      sticky_d = sticky_q;
    end
    if (push_s) begin
      sticky_d = sticky_d | i_status;
    end else begin
      sticky_d = sticky_d;
    end
  end

  // Sticky status accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_q <= 4'b0000;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign o_sticky = sticky_q;
`else
  logic unused_clear_sticky_s;

  assign unused_clear_sticky_s = i_clear_sticky;
  assign o_sticky              = 4'b0000;
`endif

endmodule

// File: tb/tb_comparison_result_buffer.sv
// Directed self-checking bench for comparison_result_buffer (K=8, DEPTH=4).
// Inputs are driven 1 ns after the rising edge, and outputs are sampled at that same point.

module tb_comparison_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] eqa;
  logic [3:0] status;
  logic       valid_out;
  logic       ready_in;
  logic [7:0] result;
  logic [3:0] res_status;
  logic [2:0] count;
  logic [3:0] sticky;
  logic       clear_sticky;

  int checks;
  int errors;

  comparison_result_buffer #(.K(8), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid_in),
    .o_ready        (ready_out),
    .i_eqA          (eqa),
    .i_status       (status),
    .o_valid        (valid_out),
    .i_ready        (ready_in),
    .o_result       (result),
    .o_res_status   (res_status),
    .o_count        (count),
    .o_sticky       (sticky),
    .i_clear_sticky (clear_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected sticky values depend on the build.
  function automatic logic [3:0] stk(input logic [3:0] v);
`ifdef COMPARISON_BUF_STICKY_EN
    return v;
`else
    return 4'b0000;
`endif
  endfunction

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    ready_in     = 1'b0;
    eqa          = 8'h00;
    status       = 4'h0;
    clear_sticky = 1'b0;
    #12;
    chk("rst_ready",  32'(ready_out), 32'd1);
    chk("rst_valid",  32'(valid_out), 32'd0);
    chk("rst_count",  32'(count),     32'd0);
    chk("rst_sticky", 32'(sticky),    32'd0);
    step();
    rst_n = 1'b1;

    // Fill to full with the consumer stalled.
    for (int i = 1; i <= 4; i++) begin
      valid_in = 1'b1;
      eqa      = 8'(i);
      status   = 4'h0;
      step();
      chk("fill_count", 32'(count), 32'(i));
    end
    chk("full_ready", 32'(ready_out), 32'd0);
    valid_in = 1'b1;
    eqa      = 8'h05;
    step();
    chk("full_no_push", 32'(count),  32'd4);
    chk("full_head",    32'(result), 32'h01);

    // Drain and wrap. 05 is held while the buffer is full, and 06 follows.
    ready_in = 1'b1;
    chk("drain_01", 32'(result), 32'h01);
    step();
    chk("drain_cnt_a", 32'(count), 32'd3);
    chk("drain_02", 32'(result), 32'h02);
    step();
    eqa = 8'h06;
    chk("drain_03", 32'(result), 32'h03);
    step();
    valid_in = 1'b0;
    chk("drain_cnt_b", 32'(count), 32'd3);
    chk("drain_04", 32'(result), 32'h04);
    step();
    chk("drain_05", 32'(result), 32'h05);
    step();
    chk("drain_06", 32'(result), 32'h06);
    chk("drain_v6", 32'(valid_out), 32'd1);
    step();
    chk("drain_valid0", 32'(valid_out), 32'd0);
    chk("drain_cnt0",   32'(count),     32'd0);

    // Concurrent traffic at a steady count of 2.
    ready_in = 1'b0;
    valid_in = 1'b1;
    eqa      = 8'hA0;
    step();
    eqa = 8'hA1;
    step();
    chk("conc_pre", 32'(count), 32'd2);
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      eqa = 8'hA2 + 8'(i);
      chk("conc_head", 32'(result), 32'hA0 + 32'(i));
      step();
      chk("conc_count", 32'(count), 32'd2);
    end
    valid_in = 1'b0;
    chk("conc_tail0", 32'(result), 32'hAA);
    step();
    chk("conc_tail1", 32'(result), 32'hAB);
    step();
    chk("conc_empty", 32'(count), 32'd0);

    // Sticky accumulation, then a clear coinciding with a push, then a bare clear.
    valid_in = 1'b1;
    eqa      = 8'h31;
    status   = 4'b1000;
    step();
    chk("head_status", 32'(res_status), 32'h8);
    eqa    = 8'h32;
    status = 4'b0001;
    step();
    valid_in = 1'b0;
    chk("sticky_or", 32'(sticky), 32'(stk(4'b1001)));
    valid_in     = 1'b1;
    clear_sticky = 1'b1;
    eqa          = 8'h33;
    status       = 4'b0100;
    step();
    valid_in = 1'b0;
    chk("sticky_clr_push", 32'(sticky), 32'(stk(4'b0100)));
    step();
    clear_sticky = 1'b0;
    chk("sticky_clr", 32'(sticky), 32'd0);
    step();
    chk("sticky_empty", 32'(count), 32'd0);

    // Mid-operation reset with 3 entries held and sticky equal to 1000.
    ready_in = 1'b0;
    valid_in = 1'b1;
    eqa      = 8'h11;
    status   = 4'b1000;
    step();
    status = 4'b0000;
    eqa    = 8'h12;
    step();
    eqa = 8'h13;
    step();
    valid_in = 1'b0;
    chk("pre_rst_count",  32'(count),  32'd3);
    chk("pre_rst_sticky", 32'(sticky), 32'(stk(4'b1000)));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid",  32'(valid_out), 32'd0);
    chk("async_ready",  32'(ready_out), 32'd1);
    chk("async_count",  32'(count),     32'd0);
    chk("async_sticky", 32'(sticky),    32'd0);
    step();
    rst_n = 1'b1;
    step();
    valid_in = 1'b1;
    eqa      = 8'h55;
    step();
    valid_in = 1'b0;
    chk("post_rst_valid", 32'(valid_out), 32'd1);
    chk("post_rst_count", 32'(count),     32'd1);
    chk("post_rst_head",  32'(result),    32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
